// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the external memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    D_HOLD = 2'd3
  } state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int DEF_BEATS    = 8;
  localparam int DEF_DW       = 64;
  localparam int DEF_AW       = 64;
  localparam int DEF_LOCK_MAX = 16;

endpackage

// File: rtl/mem_arb_beat_cnt.sv
// Wrapping up-counter with terminal-count flag; used for burst beats and lock idle time.
module mem_arb_beat_cnt #(
  parameter int TC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_i,
  input  logic                  clr_i,
  output logic [$clog2(TC)-1:0] cnt_o,
  output logic                  last_o
);

  localparam int CW = $clog2(TC);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CW'(TC - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one burst memory port between I-cache and D-cache refill engines.
// state  | meaning
// IDLE   | no burst; arbitrate i_req/d_req
// BUSY_I | I read burst on the bus
// BUSY_D | D read or write burst on the bus
// D_HOLD | D lock held after a burst; I side blocked until d_req, unlock or timeout
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int BEATS    = DEF_BEATS,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_rvalid,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_wready,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic          d_done,
  input  logic          d_lock,
  output logic          lock_to,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack
);

  localparam int BW = $clog2(BEATS);
  localparam int LW = $clog2(LOCK_MAX);

  state_e        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic          lock_to_q, lock_to_d;

  logic          busy_i, busy_d, busy, hold;
  logic [BW-1:0] beat;
  logic          beat_last;
  logic [LW-1:0] lock_cnt;
  logic          lock_last;
  logic          burst_done, lock_idle, lock_expire;
  logic          gnt_i, gnt_d;
  logic          unused;

  assign busy_i     = (state_q == BUSY_I);
  assign busy_d     = (state_q == BUSY_D);
  assign busy       = busy_i | busy_d;
  assign hold       = (state_q == D_HOLD);
  assign burst_done = busy & m_ack & beat_last;
  assign lock_idle  = hold & ~d_req & d_lock;
  // Expire one count early so lock_cnt and the registered lock_to land together.
  assign lock_expire = lock_idle & (lock_cnt == LW'(LOCK_MAX - 2));

  mem_arb_beat_cnt #(.TC(BEATS)) u_beat (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (busy & m_ack),
    .clr_i  (~busy),
    .cnt_o  (beat),
    .last_o (beat_last)
  );

  mem_arb_beat_cnt #(.TC(LOCK_MAX)) u_lock (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (lock_idle),
    .clr_i  (~lock_idle),
    .cnt_o  (lock_cnt),
    .last_o (lock_last)
  );

  assign unused = ^{beat, lock_last};

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    lock_to_d  = 1'b0;
    gnt_i      = 1'b0;
    gnt_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req && (!d_req || last_gnt_q == GNT_D)) begin
          gnt_i = 1'b1;
        end else if (d_req) begin
          gnt_d = 1'b1;
        end
      end
      BUSY_I: begin
        if (burst_done) begin
          state_d = IDLE;
          m_req_d = 1'b0;
        end
      end
      BUSY_D: begin
        if (burst_done) begin
          state_d = d_lock ? D_HOLD : IDLE;
          m_req_d = 1'b0;
        end
      end
      D_HOLD: begin
        if (d_req) begin
          gnt_d = 1'b1;
        end else if (!d_lock) begin
          state_d = IDLE;
        end else if (lock_expire) begin
          state_d    = IDLE;
          lock_to_d  = 1'b1;
          last_gnt_d = GNT_D;
        end
      end
      default: state_d = IDLE;
    endcase

    if (gnt_i) begin
      state_d    = BUSY_I;
      m_req_d    = 1'b1;
      m_we_d     = 1'b0;
      m_addr_d   = i_addr;
      last_gnt_d = GNT_I;
    end
    if (gnt_d) begin
      state_d    = BUSY_D;
      m_req_d    = 1'b1;
      m_we_d     = d_we;
      m_addr_d   = d_addr;
      last_gnt_d = GNT_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= GNT_D;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      lock_to_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      lock_to_q  <= lock_to_d;
    end
  end

  // Beat-level handshakes are combinational so data never waits a cycle.
  assign i_rvalid = busy_i & m_ack;
  assign i_rdata  = busy_i ? m_rdata : '0;
  assign i_done   = busy_i & m_ack & beat_last;
  assign d_rvalid = busy_d & ~m_we_q & m_ack;
  assign d_rdata  = (busy_d & ~m_we_q) ? m_rdata : '0;
  assign d_wready = busy_d & m_we_q & m_ack;
  assign d_done   = busy_d & m_ack & beat_last;
  assign m_wdata  = (busy_d & m_we_q) ? d_wdata : '0;

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign lock_to = lock_to_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: grant timing, round robin, bursts, AMO lock and reset behaviour.
module tb_mem_arb;
  localparam int AW = 64, DW = 64, BEATS = 8, LOCK_MAX = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_rvalid, i_done;
  logic          d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_wready, d_rvalid, d_done;
  logic [DW-1:0] d_rdata;
  logic          lock_to, m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ack = 1'b0;

  int            n_checks = 0;
  int            n_fail = 0;
  int            ack_mode = 0;
  bit            ack_ph = 1'b0;
  logic [DW-1:0] wcap [0:15];
  int            widx = 0;

  mem_arb #(.AW(AW), .DW(DW), .BEATS(BEATS), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done), .d_lock(d_lock), .lock_to(lock_to),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] wval(input int i);
    return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0000_0101_0000_0011);
  endfunction

  // Advance to the next cycle; memory model acks while m_req is high.
  task automatic step();
    @(negedge clk);
    ack_ph  = ~ack_ph;
    m_ack   = m_req && (ack_mode == 0 || ack_ph);
    m_rdata = {$urandom, $urandom};
    #1;
  endtask

  task automatic wait_done(input bit dside, output int nstrobe, output int nbad, output bit to);
    logic strobe;
    nstrobe = 0;
    nbad    = 0;
    to      = 1'b1;
    for (int c = 0; c < 64; c++) begin
      strobe = dside ? (d_we ? d_wready : d_rvalid) : i_rvalid;
      if (strobe !== m_ack) nbad++;
      if (strobe === 1'b1) nstrobe++;
      if (dside ? (i_rvalid !== 1'b0) : ((d_rvalid | d_wready) !== 1'b0)) nbad++;
      if (dside && ((d_we ? d_rvalid : d_wready) !== 1'b0)) nbad++;
      if (!dside && i_rvalid && i_rdata !== m_rdata) nbad++;
      if (dside && !d_we && d_rvalid && d_rdata !== m_rdata) nbad++;
      if (dside && d_we && d_wready) begin
        if (widx < 16) wcap[widx] = m_wdata;
        widx++;
        d_wdata = wval(widx);
      end
      if ((dside ? d_done : i_done) === 1'b1) begin
        to = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; m_ack = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1;
    i_addr = '1; d_addr = '1; d_wdata = wval(3); m_rdata = '1; m_ack = 1'b1;
    #3;
    n_checks++;
    if ({m_req, m_we, lock_to} !== 3'b000) begin
      n_fail++; $display("FAIL rst_regs: got req/we/to=%b want 000", {m_req, m_we, lock_to});
    end
    n_checks++;
    if (m_addr !== '0) begin
      n_fail++; $display("FAIL rst_addr: got %h want 0", m_addr);
    end
    n_checks++;
    if ({i_rvalid, i_done, d_rvalid, d_wready, d_done} !== 5'b0) begin
      n_fail++; $display("FAIL rst_strobes: got %b want 00000", {i_rvalid, i_done, d_rvalid, d_wready, d_done});
    end
    n_checks++;
    if ((i_rdata | d_rdata | m_wdata) !== '0) begin
      n_fail++; $display("FAIL rst_data: got i=%h d=%h w=%h want 0", i_rdata, d_rdata, m_wdata);
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; m_ack = 1'b0; rst_n = 1'b1;
    #1;
    step();
    n_checks++;
    if (m_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: got m_req=%b want 0", m_req);
    end
  endtask

  task automatic test_single_i();
    int ns, nb; bit to;
    ack_mode = 0;
    i_addr = 64'h8000_0040; i_req = 1'b1;
    n_checks++;
    if (m_req !== 1'b0) begin
      n_fail++; $display("FAIL i_latency: got m_req=%b want 0", m_req);
    end
    step();
    n_checks++;
    if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 64'h8000_0040) begin
      n_fail++; $display("FAIL i_grant: got req=%b we=%b addr=%h want 1 0 8000_0040", m_req, m_we, m_addr);
    end
    wait_done(1'b0, ns, nb, to);
    n_checks++;
    if (to || ns != BEATS) begin
      n_fail++; $display("FAIL i_beats: got %0d (timeout=%0b) want %0d", ns, to, BEATS);
    end
    n_checks++;
    if (nb != 0) begin
      n_fail++; $display("FAIL i_data: got %0d bad beats want 0", nb);
    end
    i_req = 1'b0;
    step();
    n_checks++;
    if (m_req !== 1'b0 || i_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL i_release: got req=%b rvalid=%b want 0 0", m_req, i_rvalid);
    end
  endtask

  task automatic test_tie_alternate();
    int ns, nb; bit to; bit want_d;
    apply_reset();
    ack_mode = 0;
    i_addr = 64'h8000_1000; d_addr = 64'h9000_2000; d_we = 1'b0; d_lock = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      want_d = g[0];
      step();
      n_checks++;
      if (m_req !== 1'b1 || m_addr !== (want_d ? d_addr : i_addr)) begin
        n_fail++; $display("FAIL order_%0d: got req=%b addr=%h want 1 %h", g, m_req, m_addr, want_d ? d_addr : i_addr);
      end
      wait_done(want_d, ns, nb, to);
      n_checks++;
      if (to || ns != BEATS || nb != 0) begin
        n_fail++; $display("FAIL order_burst_%0d: got beats=%0d bad=%0d to=%0b want %0d 0 0", g, ns, nb, to, BEATS);
      end
      if (want_d) d_req = 1'b0; else i_req = 1'b0;
      step();
      n_checks++;
      if (m_req !== 1'b0) begin
        n_fail++; $display("FAIL order_gap_%0d: got m_req=%b want 0", g, m_req);
      end
      if (g < 2) begin
        if (want_d) d_req = 1'b1; else i_req = 1'b1;
      end
    end
  endtask

  task automatic test_d_write();
    int ns, nb; bit to;
    ack_mode = 1; widx = 0;
    d_we = 1'b1; d_lock = 1'b0; d_addr = 64'hA000_0100; d_wdata = wval(0); d_req = 1'b1;
    step();
    n_checks++;
    if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 64'hA000_0100) begin
      n_fail++; $display("FAIL wr_grant: got req=%b we=%b addr=%h want 1 1 a000_0100", m_req, m_we, m_addr);
    end
    wait_done(1'b1, ns, nb, to);
    n_checks++;
    if (to || ns != BEATS || nb != 0) begin
      n_fail++; $display("FAIL wr_burst: got beats=%0d bad=%0d to=%0b want %0d 0 0", ns, nb, to, BEATS);
    end
    for (int k = 0; k < BEATS; k++) begin
      n_checks++;
      if (wcap[k] !== wval(k)) begin
        n_fail++; $display("FAIL wr_data_%0d: got %h want %h", k, wcap[k], wval(k));
      end
    end
    d_req = 1'b0; d_we = 1'b0;
    step();
    n_checks++;
    if (m_req !== 1'b0 || m_wdata !== '0) begin
      n_fail++; $display("FAIL wr_release: got req=%b wdata=%h want 0 0", m_req, m_wdata);
    end
  endtask

  task automatic test_amo();
    int ns, nb, nreq; bit to;
    ack_mode = 0;
    d_we = 1'b0; d_lock = 1'b1; d_addr = 64'hB000_0000; d_req = 1'b1; i_req = 1'b0;
    step();
    n_checks++;
    if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 64'hB000_0000) begin
      n_fail++; $display("FAIL amo_rd_grant: got req=%b we=%b addr=%h want 1 0 b000_0000", m_req, m_we, m_addr);
    end
    i_addr = 64'h8000_3000; i_req = 1'b1;
    wait_done(1'b1, ns, nb, to);
    n_checks++;
    if (to || ns != BEATS || nb != 0) begin
      n_fail++; $display("FAIL amo_rd_burst: got beats=%0d bad=%0d to=%0b want %0d 0 0", ns, nb, to, BEATS);
    end
    d_req = 1'b0;
    nreq = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (m_req !== 1'b0) nreq++;
    end
    n_checks++;
    if (nreq != 0) begin
      n_fail++; $display("FAIL amo_hold: got %0d cycles with m_req want 0", nreq);
    end
    widx = 0; d_wdata = wval(0); d_we = 1'b1; d_lock = 1'b0; d_addr = 64'hB000_0040; d_req = 1'b1;
    step();
    n_checks++;
    if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 64'hB000_0040) begin
      n_fail++; $display("FAIL amo_wr_grant: got req=%b we=%b addr=%h want 1 1 b000_0040", m_req, m_we, m_addr);
    end
    wait_done(1'b1, ns, nb, to);
    n_checks++;
    if (to || ns != BEATS || nb != 0) begin
      n_fail++; $display("FAIL amo_wr_burst: got beats=%0d bad=%0d to=%0b want %0d 0 0", ns, nb, to, BEATS);
    end
    d_req = 1'b0; d_we = 1'b0;
    step();
    step();
    n_checks++;
    if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 64'h8000_3000) begin
      n_fail++; $display("FAIL amo_i_after: got req=%b we=%b addr=%h want 1 0 8000_3000", m_req, m_we, m_addr);
    end
    wait_done(1'b0, ns, nb, to);
    i_req = 1'b0;
    step();
  endtask

  task automatic test_lock_timeout();
    int ns, nb, nreq, first; bit to;
    ack_mode = 0;
    d_we = 1'b0; d_lock = 1'b1; d_addr = 64'hB000_0080; d_req = 1'b1; i_req = 1'b0;
    step();
    n_checks++;
    if (m_req !== 1'b1 || m_addr !== 64'hB000_0080) begin
      n_fail++; $display("FAIL to_grant: got req=%b addr=%h want 1 b000_0080", m_req, m_addr);
    end
    i_addr = 64'h8000_4000; i_req = 1'b1;
    wait_done(1'b1, ns, nb, to);
    d_req = 1'b0;
    first = -1; nreq = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (m_req !== 1'b0) nreq++;
      if (lock_to === 1'b1) begin
        first = k;
        break;
      end
    end
    n_checks++;
    if (first != LOCK_MAX) begin
      n_fail++; $display("FAIL to_cycle: got lock_to at %0d want %0d", first, LOCK_MAX);
    end
    n_checks++;
    if (nreq != 0) begin
      n_fail++; $display("FAIL to_hold: got %0d cycles with m_req want 0", nreq);
    end
    step();
    n_checks++;
    if (lock_to !== 1'b0) begin
      n_fail++; $display("FAIL to_pulse: got lock_to=%b want 0", lock_to);
    end
    n_checks++;
    if (m_req !== 1'b1 || m_addr !== 64'h8000_4000) begin
      n_fail++; $display("FAIL to_i_grant: got req=%b addr=%h want 1 8000_4000", m_req, m_addr);
    end
    d_lock = 1'b0;
    wait_done(1'b0, ns, nb, to);
    i_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int ns, nb, nv; bit to;
    ack_mode = 0;
    i_addr = 64'h8000_5000; i_req = 1'b1; d_req = 1'b0;
    step();
    nv = 0;
    for (int c = 0; c < 20 && nv < 4; c++) begin
      if (i_rvalid === 1'b1) nv++;
      step();
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_req !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_req: got m_req=%b want 0", m_req);
    end
    n_checks++;
    if (i_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_rvalid: got i_rvalid=%b want 0 (m_ack=%b)", i_rvalid, m_ack);
    end
    i_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; m_ack = 1'b1;
    #1;
    n_checks++;
    if ({i_rvalid, i_done, d_rvalid, d_wready} !== 4'b0) begin
      n_fail++; $display("FAIL late_ack: got %b want 0000", {i_rvalid, i_done, d_rvalid, d_wready});
    end
    step();
    n_checks++;
    if (m_req !== 1'b0) begin
      n_fail++; $display("FAIL late_ack_idle: got m_req=%b want 0", m_req);
    end
    i_req = 1'b1;
    step();
    n_checks++;
    if (m_req !== 1'b1 || m_addr !== 64'h8000_5000) begin
      n_fail++; $display("FAIL mid_regrant: got req=%b addr=%h want 1 8000_5000", m_req, m_addr);
    end
    wait_done(1'b0, ns, nb, to);
    n_checks++;
    if (to || ns != BEATS || nb != 0) begin
      n_fail++; $display("FAIL mid_full_burst: got beats=%0d bad=%0d to=%0b want %0d 0 0", ns, nb, to, BEATS);
    end
    i_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_tie_alternate();
    test_d_write();
    test_amo();
    test_lock_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
